otter_divider: RTL and testbench

//  Iterative 32-bit RV32M divide/remainder unit (DIV, DIVU, REM, REMU), one quotient bit per cycle.

---
 rtl/otter_divider_pkg.sv | 29 ++
 rtl/otter_div_step.sv | 27 ++
 rtl/otter_divider.sv | 193 +++++++++++++++++++
 tb/tb_otter_divider.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_divider_pkg.sv
// rtl/otter_divider_pkg.sv - shared op codes, FSM states and sign helpers for otter_divider
package otter_divider_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'b00,
    DIV_ST_BUSY = 2'b01,
    DIV_ST_FIX  = 2'b10,
    DIV_ST_DONE = 2'b11
  } div_state_e;

  // Magnitude through a 33-bit intermediate so |0x80000000| survives as 0x80000000.
  function automatic logic [31:0] div_mag(input logic [31:0] v, input logic neg);
    logic [32:0] wide;
    wide = {v[31], v};
    if (neg) wide = 33'd0 - wide;
    return wide[31:0];
  endfunction

  // Conditional two's-complement negate used when restoring result signs.
  function automatic logic [31:0] div_apply_sign(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/otter_div_step.sv
// rtl/otter_div_step.sv - one combinational restoring-division step
module otter_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // Shift {rem,quo} left, try subtracting the divisor, keep it when no borrow.
  always_comb begin
    shifted = {rem_in, quo_in[XLEN-1]};
    trial   = shifted - {1'b0, divisor};
    rem_out = shifted[XLEN-1:0];
    quo_out = {quo_in[XLEN-2:0], 1'b0};
    if (!trial[XLEN]) begin
      rem_out = trial[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/otter_divider.sv
// rtl/otter_divider.sv - iterative RV32M divide/remainder unit; optional last-result cache via OTTER_DIV_CACHE_EN
module otter_divider
  import otter_divider_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_src_a,
  input  logic [XLEN-1:0] i_src_b,
  input  logic            i_kill,
  output logic            o_ready,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state;
  logic [4:0]      count;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] div_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic            is_rem_q;
  logic            fast_q;
  logic [XLEN-1:0] fast_res_q;

  logic            in_signed;
  logic            in_rem;
  logic            in_div_zero;
  logic            in_overflow;
  logic            in_special;
  logic [XLEN-1:0] in_special_res;
  logic            in_sign_a;
  logic            in_sign_b;
  logic            cache_hit;
  logic [XLEN-1:0] cache_res;
  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] step_quo;
  logic [XLEN-1:0] fin_quo;
  logic [XLEN-1:0] fin_rem;

  assign o_ready = (state == DIV_ST_IDLE);

  assign in_signed      = ~i_op[0];
  assign in_rem         = i_op[1];
  assign in_div_zero    = (i_src_b == '0);
  assign in_overflow    = in_signed && (i_src_a == MIN_NEG) && (i_src_b == '1);
  assign in_special     = in_div_zero || in_overflow;
  assign in_special_res = in_div_zero ? (in_rem ? i_src_a : '1)
                                      : (in_rem ? '0 : MIN_NEG);
  assign in_sign_a      = in_signed & i_src_a[XLEN-1];
  assign in_sign_b      = in_signed & i_src_b[XLEN-1];

  assign fin_quo = div_apply_sign(quo_q, neg_quo_q);
  assign fin_rem = div_apply_sign(rem_q, neg_rem_q);

`ifdef OTTER_DIV_CACHE_EN
  logic            cache_valid;
  logic [XLEN-1:0] cache_a;
  logic [XLEN-1:0] cache_b;
  logic            cache_signed;
  logic [XLEN-1:0] cache_quo;
  logic [XLEN-1:0] cache_rem;
  logic [XLEN-1:0] op_a_q;
  logic [XLEN-1:0] op_b_q;
  logic            op_signed_q;

  assign cache_hit = cache_valid && (cache_a == i_src_a) && (cache_b == i_src_b)
                     && (cache_signed == in_signed);
  assign cache_res = in_rem ? cache_rem : cache_quo;
`else
  assign cache_hit = 1'b0;
  assign cache_res = '0;
`endif

  otter_div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (div_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // Control FSM: accept, iterate 32 steps, sign-fix and publish, single-cycle done pulse.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= DIV_ST_IDLE;
      count      <= '0;
      o_valid    <= 1'b0;
      o_result   <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      div_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      is_rem_q   <= 1'b0;
      fast_q     <= 1'b0;
      fast_res_q <= '0;
`ifdef OTTER_DIV_CACHE_EN
      cache_valid  <= 1'b0;
      cache_a      <= '0;
      cache_b      <= '0;
      cache_signed <= 1'b0;
      cache_quo    <= '0;
      cache_rem    <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_signed_q  <= 1'b0;
`endif
    end else begin
      o_valid <= 1'b0;
      case (state)
        DIV_ST_IDLE: begin
          if (i_valid && !i_kill) begin
            is_rem_q <= in_rem;
`ifdef OTTER_DIV_CACHE_EN
            op_a_q      <= i_src_a;
            op_b_q      <= i_src_b;
            op_signed_q <= in_signed;
`endif
            if (in_special) begin
              fast_q     <= 1'b1;
              fast_res_q <= in_special_res;
              state      <= DIV_ST_FIX;
            end else if (cache_hit) begin
              fast_q     <= 1'b1;
              fast_res_q <= cache_res;
              state      <= DIV_ST_FIX;
            end else begin
              fast_q    <= 1'b0;
              rem_q     <= '0;
              quo_q     <= div_mag(i_src_a, in_sign_a);
              div_q     <= div_mag(i_src_b, in_sign_b);
              neg_quo_q <= in_sign_a ^ in_sign_b;
              neg_rem_q <= in_sign_a;
              count     <= '0;
              state     <= DIV_ST_BUSY;
            end
          end
        end
        DIV_ST_BUSY: begin
          if (i_kill) begin
            state <= DIV_ST_IDLE;
            count <= '0;
`ifdef OTTER_DIV_CACHE_EN
            cache_valid <= 1'b0;
`endif
          end else begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            count <= count + 5'd1;
            if (count == 5'd31) state <= DIV_ST_FIX;
          end
        end
        DIV_ST_FIX: begin
          if (i_kill) begin
            state <= DIV_ST_IDLE;
`ifdef OTTER_DIV_CACHE_EN
            cache_valid <= 1'b0;
`endif
          end else begin
            o_valid  <= 1'b1;
            o_result <= fast_q ? fast_res_q : (is_rem_q ? fin_rem : fin_quo);
            state    <= DIV_ST_DONE;
`ifdef OTTER_DIV_CACHE_EN
            if (!fast_q) begin
              cache_valid  <= 1'b1;
              cache_a      <= op_a_q;
              cache_b      <= op_b_q;
              cache_signed <= op_signed_q;
              cache_quo    <= fin_quo;
              cache_rem    <= fin_rem;
            end
`endif
          end
        end
        DIV_ST_DONE: begin
          state <= DIV_ST_IDLE;
`ifdef OTTER_DIV_CACHE_EN
          if (i_kill) cache_valid <= 1'b0;
`endif
        end
        default: state <= DIV_ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_divider.sv
// tb/tb_otter_divider.sv - self-checking bench for otter_divider (either OTTER_DIV_CACHE_EN build)
module tb_otter_divider;

`ifdef OTTER_DIV_CACHE_EN
  localparam int HIT = 1;
  localparam bit CACHE_ON = 1'b1;
`else
  localparam int HIT = 33;
  localparam bit CACHE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [1:0]  i_op = 2'b00;
  logic [31:0] i_src_a = '0;
  logic [31:0] i_src_b = '0;
  logic        i_kill = 1'b0;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_result;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  bit          mon_en = 1'b0;
  bit          pend = 1'b0;
  bit          done = 1'b0;
  int          acc_cyc = 0;
  int          exp_lat = 0;
  logic [31:0] exp_res = '0;
  logic [31:0] last_res = '0;

  bit          mc_valid = 1'b0;
  logic [31:0] mc_a = '0;
  logic [31:0] mc_b = '0;
  bit          mc_signed = 1'b0;

  otter_divider dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (i_valid),
    .i_op     (i_op),
    .i_src_a  (i_src_a),
    .i_src_b  (i_src_b),
    .i_kill   (i_kill),
    .o_ready  (o_ready),
    .o_valid  (o_valid),
    .o_result (o_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit op_signed(input logic [1:0] op);
    return (op == 2'b00) || (op == 2'b10);
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (op_signed(op) && a == 32'h80000000 && b == 32'hFFFFFFFF);
  endfunction

  // RISC-V M-extension semantics from plain integer arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit want_rem;
    longint sa, sb, q, r;
    want_rem = (op == 2'b10) || (op == 2'b11);
    if (b == 32'd0) return want_rem ? a : 32'hFFFFFFFF;
    if (op_signed(op) && a == 32'h80000000 && b == 32'hFFFFFFFF)
      return want_rem ? 32'd0 : 32'h80000000;
    if (op_signed(op)) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return want_rem ? 32'(r) : 32'(q);
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (is_special(op, a, b)) return 1;
    if (CACHE_ON && mc_valid && mc_a == a && mc_b == b && mc_signed == op_signed(op)) return 1;
    return 33;
  endfunction

  // Single compare process: o_valid only when expected, result and latency, result held otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_valid) begin
        total++;
        if (!pend) begin
          bad++;
          $display("FAIL spurious_valid: o_valid=1 result=%h, required no completion", o_result);
        end else begin
          total++;
          if (o_result !== exp_res) begin
            bad++;
            $display("FAIL result: got %h, expected %h", o_result, exp_res);
          end
          if ((cyc - acc_cyc) != exp_lat) begin
            bad++;
            $display("FAIL latency: got %0d, expected %0d", cyc - acc_cyc, exp_lat);
          end
          last_res = exp_res;
          pend = 1'b0;
          done = 1'b1;
        end
      end else begin
        total++;
        if (o_result !== last_res) begin
          bad++;
          $display("FAIL result_hold: got %h, expected %h", o_result, last_res);
        end
        if (pend && (cyc - acc_cyc) > exp_lat) begin
          total++;
          bad++;
          $display("FAIL timeout: no o_valid after %0d cycles, expected %0d", cyc - acc_cyc, exp_lat);
          pend = 1'b0;
          done = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    @(negedge clk);
    while (o_ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (o_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ready_wait: o_ready=%b after %0d cycles, expected 1", o_ready, k);
    end
  endtask

  task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    wait_ready();
    i_valid = 1'b1;
    i_op    = op;
    i_src_a = a;
    i_src_b = b;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] lit_res, input int lit_lat);
    logic [31:0] m_res;
    int          m_lat;
    int          k;
    m_res = ref_div(op, a, b);
    m_lat = ref_lat(op, a, b);
    check({name, "_model_res"}, m_res, lit_res);
    check({name, "_model_lat"}, m_lat, lit_lat);
    exp_res = m_res;
    exp_lat = m_lat;
    done    = 1'b0;
    accept(op, a, b);
    pend = 1'b1;
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!done) begin
      total++;
      bad++;
      pend = 1'b0;
      $display("FAIL %s_no_done: completion not seen, expected within %0d cycles", name, m_lat);
    end
    if (!is_special(op, a, b)) begin
      mc_valid  = 1'b1;
      mc_a      = a;
      mc_b      = b;
      mc_signed = op_signed(op);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, o_ready}, 32'd1);
    check("reset_valid", {31'd0, o_valid}, 32'd0);
    check("reset_result", o_result, 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    issue("div_20_m3",   2'b00, 32'd20, 32'hFFFFFFFD, 32'hFFFFFFFA, 33);
    issue("rem_20_m3",   2'b10, 32'd20, 32'hFFFFFFFD, 32'h00000002, HIT);
    issue("divu_max_16", 2'b01, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF, 33);
    issue("remu_max_16", 2'b11, 32'hFFFFFFFF, 32'd16, 32'h0000000F, HIT);
    issue("rem_m20_3",   2'b10, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, 33);
    issue("div_7_0",     2'b00, 32'd7, 32'd0, 32'hFFFFFFFF, 1);
    issue("remu_7_0",    2'b11, 32'd7, 32'd0, 32'h00000007, 1);
    issue("div_ovf",     2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    issue("rem_ovf",     2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

    // Kill 10 cycles into DIVU 100/7.
    accept(2'b01, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    i_kill = 1'b1;
    @(posedge clk);
    #1;
    i_kill = 1'b0;
    mc_valid = 1'b0;
    check("kill_ready", {31'd0, o_ready}, 32'd1);
    check("kill_valid", {31'd0, o_valid}, 32'd0);
    check("kill_result", o_result, last_res);
    repeat (40) @(posedge clk);
    issue("divu_100_7",  2'b01, 32'd100, 32'd7, 32'd14, 33);

    // Kill together with valid in IDLE drops the request.
    wait_ready();
    i_valid = 1'b1;
    i_kill  = 1'b1;
    i_op    = 2'b00;
    i_src_a = 32'd50;
    i_src_b = 32'd5;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_kill  = 1'b0;
    check("idle_kill_ready", {31'd0, o_ready}, 32'd1);
    repeat (5) @(posedge clk);

    // Reset in the middle of an operation.
    accept(2'b00, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    last_res = 32'd0;
    mc_valid = 1'b0;
    rst_n    = 1'b1;
    check("midrst_ready", {31'd0, o_ready}, 32'd1);
    check("midrst_valid", {31'd0, o_valid}, 32'd0);
    check("midrst_result", o_result, 32'd0);

    issue("div_100_7",   2'b00, 32'd100, 32'd7, 32'd14, 33);
    issue("rem_100_7",   2'b10, 32'd100, 32'd7, 32'd2, HIT);
    issue("divu_min_m1", 2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);
    issue("div_m7_2",    2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    issue("rem_min_3",   2'b10, 32'h80000000, 32'd3, 32'hFFFFFFFE, 33);
    issue("div_min_3",   2'b00, 32'h80000000, 32'd3, 32'hD5555556, HIT);
    issue("remu_eq",     2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
